// File: rtl/fetch_queue.sv
// Instruction fetch stage: drives the synchronous imem and buffers returned
// instructions with their PCs in a small prefetch FIFO presented to decode.
module fetch_queue #(
    parameter int PC_WIDTH = 12,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                clock,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] address_imem,
    input  logic [31:0]         q_imem,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_insn,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [4:0]          out_opcode,
    output logic [CW-1:0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);
    localparam logic [PW-1:0]       PTR_ONE = PW'(1);
    localparam logic [CW-1:0]       CNT_ONE = CW'(1);
    localparam logic [CW:0]         DEPTH_W = (CW + 1)'(DEPTH);

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] req_pc;
    logic                req_q;
    logic [31:0]         insn_mem [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem [DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic [CW-1:0]       count_q;

    logic                issue;
    logic                push;
    logic                pop;
    logic [CW:0]         pending;

    // An in-flight read reserves a slot, so a push can never land on a full FIFO.
    always_comb begin
        pending = {1'b0, count_q} + {{CW{1'b0}}, req_q};
        issue   = (pending < DEPTH_W);
        push    = req_q;
        pop     = out_valid & out_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= '0;
            req_q    <= 1'b0;
            req_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            req_q    <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + PC_ONE;
                req_pc   <= fetch_pc;
                req_q    <= 1'b1;
            end else begin
                req_q    <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (!reset && !redirect_valid && push) begin
            insn_mem[wr_ptr] <= q_imem;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

    always_comb begin
        address_imem = fetch_pc;
        count        = count_q;
        out_valid    = (count_q != '0);
        out_insn     = out_valid ? insn_mem[rd_ptr] : 32'd0;
        out_pc       = out_valid ? pc_mem[rd_ptr] : '0;
        out_opcode   = out_insn[31:27];
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a one-cycle-latency imem model.
module tb_fetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] address_imem;
    logic [31:0] q_imem;
    logic        redirect_valid;
    logic [11:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [11:0] out_pc;
    logic [4:0]  out_opcode;
    logic [2:0]  count;

    logic [31:0] imem [4096];
    int total = 0;
    int passed = 0;

    fetch_queue #(.PC_WIDTH(12), .DEPTH(4)) dut (
        .clock(clock),
        .reset(reset),
        .address_imem(address_imem),
        .q_imem(q_imem),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_insn(out_insn),
        .out_pc(out_pc),
        .out_opcode(out_opcode),
        .count(count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) q_imem <= imem[address_imem];

    task tick;
        @(posedge clock);
        #1;
    endtask

    task do_reset;
        reset = 1'b1;
        redirect_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task test_reset;
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 12'h040;
        out_ready = 1'b1;
        tick();
        tick();
        total++; if (address_imem !== 12'h000) $display("[TB] FAIL reset_addr: got %0h expected 0", address_imem); else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid); else passed++;
        total++; if (out_pc !== 12'h000) $display("[TB] FAIL reset_pc: got %0h expected 0", out_pc); else passed++;
        total++; if (out_insn !== 32'h0) $display("[TB] FAIL reset_insn: got %0h expected 0", out_insn); else passed++;
        total++; if (out_opcode !== 5'h0) $display("[TB] FAIL reset_opcode: got %0h expected 0", out_opcode); else passed++;
        total++; if (count !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else passed++;
        redirect_valid = 1'b0;
        reset = 1'b0;
    endtask

    task test_first_fetch;
        logic [4:0] exp_op [4];
        exp_op[0] = 5'b00101; exp_op[1] = 5'b00000; exp_op[2] = 5'b00111; exp_op[3] = 5'b00001;
        out_ready = 1'b1;
        do_reset();
        tick();
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL first_valid_early: got %0b expected 0", out_valid); else passed++;
        total++; if (address_imem !== 12'h001) $display("[TB] FAIL first_addr: got %0h expected 1", address_imem); else passed++;
        tick();
        total++; if (out_valid !== 1'b1) $display("[TB] FAIL first_valid: got %0b expected 1", out_valid); else passed++;
        total++; if (out_insn !== 32'h28000001) $display("[TB] FAIL first_insn: got %0h expected 28000001", out_insn); else passed++;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            total++; if (out_pc !== 12'(i)) $display("[TB] FAIL stream_pc: got %0h expected %0h", out_pc, i); else passed++;
            total++; if (out_opcode !== exp_op[i]) $display("[TB] FAIL stream_opcode: got %0b expected %0b", out_opcode, exp_op[i]); else passed++;
        end
    endtask

    task test_backpressure;
        logic [11:0] exp_pc;
        int got;
        int cyc;
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (count > 3'd4) $display("[TB] FAIL bp_count_bound: got %0d expected <=4", count); else passed++;
        end
        total++; if (count !== 3'd4) $display("[TB] FAIL bp_count_full: got %0d expected 4", count); else passed++;
        total++; if (address_imem !== 12'h004) $display("[TB] FAIL bp_addr_hold: got %0h expected 4", address_imem); else passed++;
        out_ready = 1'b1;
        exp_pc = 12'h000; got = 0; cyc = 0;
        while (got < 6 && cyc < 40) begin
            if (out_valid) begin
                total++; if (out_pc !== exp_pc) $display("[TB] FAIL bp_pc: got %0h expected %0h", out_pc, exp_pc); else passed++;
                total++; if (out_insn !== imem[exp_pc]) $display("[TB] FAIL bp_insn: got %0h expected %0h", out_insn, imem[exp_pc]); else passed++;
                exp_pc++; got++;
            end
            tick(); cyc++;
        end
        total++; if (got != 6) $display("[TB] FAIL bp_timeout: got %0d pops expected 6", got); else passed++;
    endtask

    task test_redirect;
        logic [11:0] exp_pc;
        int got;
        int cyc;
        out_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        total++; if (count !== 3'd3) $display("[TB] FAIL redir_pre_count: got %0d expected 3", count); else passed++;
        total++; if (address_imem !== 12'h004) $display("[TB] FAIL redir_pre_addr: got %0h expected 4", address_imem); else passed++;
        redirect_valid = 1'b1;
        redirect_target = 12'h123;
        tick();
        redirect_valid = 1'b0;
        total++; if (count !== 3'd0) $display("[TB] FAIL redir_count: got %0d expected 0", count); else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL redir_valid0: got %0b expected 0", out_valid); else passed++;
        total++; if (address_imem !== 12'h123) $display("[TB] FAIL redir_addr: got %0h expected 123", address_imem); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL redir_valid1: got %0b expected 0", out_valid); else passed++;
        tick();
        total++; if (out_valid !== 1'b1) $display("[TB] FAIL redir_valid2: got %0b expected 1", out_valid); else passed++;
        out_ready = 1'b1;
        exp_pc = 12'h123; got = 0; cyc = 0;
        while (got < 4 && cyc < 40) begin
            if (out_valid) begin
                total++; if (out_pc !== exp_pc) $display("[TB] FAIL redir_pc: got %0h expected %0h", out_pc, exp_pc); else passed++;
                total++; if (out_insn !== imem[exp_pc]) $display("[TB] FAIL redir_insn: got %0h expected %0h", out_insn, imem[exp_pc]); else passed++;
                exp_pc++; got++;
            end
            tick(); cyc++;
        end
        total++; if (got != 4) $display("[TB] FAIL redir_timeout: got %0d pops expected 4", got); else passed++;
    endtask

    task test_wrap;
        logic [11:0] exp_pc;
        int got;
        int cyc;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 12'hFFE;
        tick();
        redirect_valid = 1'b0;
        exp_pc = 12'hFFE; got = 0; cyc = 0;
        while (got < 4 && cyc < 40) begin
            if (out_valid) begin
                total++; if (out_pc !== exp_pc) $display("[TB] FAIL wrap_pc: got %0h expected %0h", out_pc, exp_pc); else passed++;
                exp_pc++; got++;
            end
            tick(); cyc++;
        end
        total++; if (got != 4) $display("[TB] FAIL wrap_timeout: got %0d pops expected 4", got); else passed++;
    endtask

    task test_back_to_back;
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 12'h200;
        tick();
        redirect_target = 12'h300;
        tick();
        redirect_valid = 1'b0;
        total++; if (address_imem !== 12'h300) $display("[TB] FAIL b2b_addr: got %0h expected 300", address_imem); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL b2b_valid_early: got %0b expected 0", out_valid); else passed++;
        tick();
        total++; if (out_valid !== 1'b1) $display("[TB] FAIL b2b_valid: got %0b expected 1", out_valid); else passed++;
        total++; if (out_pc !== 12'h300) $display("[TB] FAIL b2b_pc: got %0h expected 300", out_pc); else passed++;
    endtask

    task test_random;
        logic [11:0] exp_pc;
        int pops;
        int bad;
        out_ready = 1'b0;
        do_reset();
        exp_pc = 12'h000; pops = 0; bad = 0;
        for (int i = 0; i < 500; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (count > 3'd4) bad++;
            if (out_valid && out_ready) begin
                total++; if (out_pc !== exp_pc) $display("[TB] FAIL rand_pc: got %0h expected %0h", out_pc, exp_pc); else passed++;
                total++; if (out_insn !== imem[exp_pc]) $display("[TB] FAIL rand_insn: got %0h expected %0h", out_insn, imem[exp_pc]); else passed++;
                exp_pc++; pops++;
            end
            tick();
        end
        total++; if (bad != 0) $display("[TB] FAIL rand_count_bound: got %0d overflows expected 0", bad); else passed++;
        total++; if (pops < 50) $display("[TB] FAIL rand_progress: got %0d pops expected >=50", pops); else passed++;
    endtask

    task test_mid_reset;
        out_ready = 1'b0;
        do_reset();
        repeat (3) tick();
        total++; if (count !== 3'd2) $display("[TB] FAIL mid_pre_count: got %0d expected 2", count); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (count !== 3'd0) $display("[TB] FAIL mid_count: got %0d expected 0", count); else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_valid0: got %0b expected 0", out_valid); else passed++;
        total++; if (address_imem !== 12'h000) $display("[TB] FAIL mid_addr: got %0h expected 0", address_imem); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_valid1: got %0b expected 0", out_valid); else passed++;
        tick();
        total++; if (out_valid !== 1'b1) $display("[TB] FAIL mid_valid2: got %0b expected 1", out_valid); else passed++;
        total++; if (out_pc !== 12'h000) $display("[TB] FAIL mid_pc: got %0h expected 0", out_pc); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            logic [11:0] a;
            a = 12'(i);
            imem[i] = {a[4:0] ^ 5'h15, 3'b000, a, a};
        end
        imem[0] = 32'h28000001;
        imem[1] = 32'h00000000;
        imem[2] = 32'h38400005;
        imem[3] = 32'h08000010;
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = 12'h000;
        out_ready = 1'b0;

        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_random();
        test_mid_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
